// File: rtl/ysyx_040750_div_pkg.sv
// ysyx_040750_div_pkg
// Shared definitions for the iterative divider:
//   div_state_e  - controller states (IDLE, CALC, FIX, DONE)
//   XLEN_DEFAULT - default operand/result width (64)
//   WORD_LEN     - width of a word-mode (DIVW/REMW class) operation (32)
package ysyx_040750_div_pkg;

    localparam int XLEN_DEFAULT = 64;
    localparam int WORD_LEN     = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/ysyx_040750_iter_div_if.sv
// ysyx_040750_iter_div_if
// Request/result bundle of the iterative divider.
//   master (requester): drives dividend, divisor, is_signed, div_word,
//                       div_valid, flush, out_ready; observes div_ready,
//                       out_valid, quotient, remainder.
//   slave  (divider)  : the mirror image.
interface ysyx_040750_iter_div_if
    import ysyx_040750_div_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
);

    logic [XLEN-1:0] dividend;
    logic [XLEN-1:0] divisor;
    logic            is_signed;
    logic            div_word;
    logic            div_valid;
    logic            div_ready;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] quotient;
    logic [XLEN-1:0] remainder;

    modport master (
        output dividend, divisor, is_signed, div_word, div_valid, flush, out_ready,
        input  div_ready, out_valid, quotient, remainder
    );

    modport slave (
        input  dividend, divisor, is_signed, div_word, div_valid, flush, out_ready,
        output div_ready, out_valid, quotient, remainder
    );

endinterface

// File: rtl/ysyx_040750_div_step.sv
// ysyx_040750_div_step
// One combinational restoring radix-2 division step.
//   rem      - current partial remainder (always < divisor, or grows freely
//              when divisor is zero)
//   dd_msb   - next dividend bit shifted into the partial remainder
//   divisor  - divisor magnitude
//   next_rem - partial remainder after this step
//   q_bit    - quotient bit produced by this step
module ysyx_040750_div_step
    import ysyx_040750_div_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] rem,
    input  logic            dd_msb,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] next_rem,
    output logic            q_bit
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // One extra bit keeps the trial subtraction exact: a set top bit of the
    // difference means the subtraction borrowed, so the old value is restored.
    always_comb begin
        shifted  = {rem, dd_msb};
        diff     = shifted - {1'b0, divisor};
        q_bit    = ~diff[XLEN];
        next_rem = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    end

endmodule

// File: rtl/ysyx_040750_iter_div.sv
// ysyx_040750_iter_div
// Iterative restoring divider (one quotient bit per cycle), signed/unsigned,
// with RV64 word-mode support.
//   clk   - clock, all state changes on its rising edge
//   rst_n - synchronous active-low reset
//   bus   - ysyx_040750_iter_div_if.slave: request (div_valid/div_ready with
//           operands), result (out_valid/out_ready with quotient/remainder)
//           and flush.
// Optional build macro YSYX_040750_DIV_FASTPATH_EN: divide-by-zero and
// signed-overflow requests skip the iteration and complete in one cycle.
module ysyx_040750_iter_div
    import ysyx_040750_div_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input logic                 clk,
    input logic                 rst_n,
    ysyx_040750_iter_div_if.slave bus
);

    localparam int CNT_W = $clog2(XLEN);

    div_state_e      state;
    logic [XLEN-1:0] rem_reg;
    logic [XLEN-1:0] dd_reg;
    logic [XLEN-1:0] ds_reg;
    logic [CNT_W-1:0] cnt;
    logic            word_reg;
    logic            neg_q;
    logic            neg_r;
    logic [XLEN-1:0] quotient_reg;
    logic [XLEN-1:0] remainder_reg;
    logic            div_ready_reg;
    logic            out_valid_reg;

    logic            word_op;
    logic [XLEN-1:0] op_dd;
    logic [XLEN-1:0] op_ds;
    logic [XLEN-1:0] abs_dd;
    logic [XLEN-1:0] abs_ds;
    logic [XLEN-1:0] dd_init;
    logic            sign_dd;
    logic            sign_ds;
    logic            ds_zero;

    logic [XLEN-1:0] step_rem;
    logic            step_q;
    logic [CNT_W-1:0] last_cnt;

    logic [XLEN-1:0] q_signed;
    logic [XLEN-1:0] r_signed;
    logic [XLEN-1:0] q_fix;
    logic [XLEN-1:0] r_fix;

    // Operand preparation: select/extend the operation width, then take
    // magnitudes. In word mode the dividend magnitude is pre-shifted to the
    // top of the register so every step can consume bit XLEN-1.
    always_comb begin
        word_op = (XLEN == 64) && bus.div_word;
        if (word_op && bus.is_signed) begin
            op_dd = XLEN'($signed(bus.dividend[WORD_LEN-1:0]));
            op_ds = XLEN'($signed(bus.divisor[WORD_LEN-1:0]));
        end else if (word_op) begin
            op_dd = XLEN'(bus.dividend[WORD_LEN-1:0]);
            op_ds = XLEN'(bus.divisor[WORD_LEN-1:0]);
        end else begin
            op_dd = bus.dividend;
            op_ds = bus.divisor;
        end
        sign_dd = bus.is_signed & op_dd[XLEN-1];
        sign_ds = bus.is_signed & op_ds[XLEN-1];
        ds_zero = (op_ds == '0);
        abs_dd  = sign_dd ? (~op_dd + 1'b1) : op_dd;
        abs_ds  = sign_ds ? (~op_ds + 1'b1) : op_ds;
        if (word_op) begin
            dd_init = abs_dd << (XLEN - WORD_LEN);
        end else begin
            dd_init = abs_dd;
        end
    end

`ifdef YSYX_040750_DIV_FASTPATH_EN
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic            fast_ovf;
    logic [XLEN-1:0] dd_ext;
    logic [XLEN-1:0] fast_q;
    logic [XLEN-1:0] fast_r;

    // Results of the special cases straight from the request; both
    // word-mode results are sign-extended from bit 31 regardless of is_signed.
    always_comb begin
        if (word_op) begin
            dd_ext   = XLEN'($signed(bus.dividend[WORD_LEN-1:0]));
            fast_ovf = bus.is_signed
                       && (bus.dividend[WORD_LEN-1:0] == 32'h8000_0000)
                       && (bus.divisor[WORD_LEN-1:0] == 32'hFFFF_FFFF);
        end else begin
            dd_ext   = bus.dividend;
            fast_ovf = bus.is_signed && (bus.dividend == MOST_NEG) && (bus.divisor == '1);
        end
        fast_q = ds_zero ? '1 : dd_ext;
        fast_r = ds_zero ? dd_ext : '0;
    end
`endif

    ysyx_040750_div_step #(
        .XLEN(XLEN)
    ) u_step (
        .rem     (rem_reg),
        .dd_msb  (dd_reg[XLEN-1]),
        .divisor (ds_reg),
        .next_rem(step_rem),
        .q_bit   (step_q)
    );

    // Sign correction of the magnitudes produced by the iteration. The
    // quotient bits shift into the low end of dd_reg, so after N steps
    // dd_reg holds the unsigned quotient.
    always_comb begin
        last_cnt = word_reg ? CNT_W'(WORD_LEN - 1) : CNT_W'(XLEN - 1);
        q_signed = neg_q ? (~dd_reg + 1'b1) : dd_reg;
        r_signed = neg_r ? (~rem_reg + 1'b1) : rem_reg;
        if (word_reg) begin
            q_fix = XLEN'($signed(q_signed[WORD_LEN-1:0]));
            r_fix = XLEN'($signed(r_signed[WORD_LEN-1:0]));
        end else begin
            q_fix = q_signed;
            r_fix = r_signed;
        end
    end

    // Controller and datapath. Reset beats flush, flush beats everything
    // else. A zero divisor never negates the quotient so it stays all-ones;
    // signed overflow falls out of the normal arithmetic.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            rem_reg       <= '0;
            dd_reg        <= '0;
            ds_reg        <= '0;
            cnt           <= '0;
            word_reg      <= 1'b0;
            neg_q         <= 1'b0;
            neg_r         <= 1'b0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            div_ready_reg <= 1'b1;
            out_valid_reg <= 1'b0;
        end else if (bus.flush) begin
            state         <= IDLE;
            cnt           <= '0;
            div_ready_reg <= 1'b1;
            out_valid_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.div_valid && div_ready_reg) begin
                        div_ready_reg <= 1'b0;
`ifdef YSYX_040750_DIV_FASTPATH_EN
                        if (ds_zero || fast_ovf) begin
                            quotient_reg  <= fast_q;
                            remainder_reg <= fast_r;
                            out_valid_reg <= 1'b1;
                            state         <= DONE;
                        end else begin
`else
                        begin
`endif
                            rem_reg  <= '0;
                            dd_reg   <= dd_init;
                            ds_reg   <= abs_ds;
                            cnt      <= '0;
                            word_reg <= word_op;
                            neg_q    <= (sign_dd ^ sign_ds) && !ds_zero;
                            neg_r    <= sign_dd;
                            state    <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_reg <= step_rem;
                    dd_reg  <= {dd_reg[XLEN-2:0], step_q};
                    cnt     <= cnt + 1'b1;
                    if (cnt == last_cnt) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    quotient_reg  <= q_fix;
                    remainder_reg <= r_fix;
                    out_valid_reg <= 1'b1;
                    state         <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        div_ready_reg <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state         <= IDLE;
                    div_ready_reg <= 1'b1;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.div_ready = div_ready_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.quotient  = quotient_reg;
    assign bus.remainder = remainder_reg;

endmodule

// File: tb/tb_ysyx_040750_iter_div.sv
// tb_ysyx_040750_iter_div
// Self-checking bench for ysyx_040750_iter_div (XLEN=64): directed corner
// cases, randomized requests against an arithmetic reference model,
// backpressure, flush and mid-operation reset.
module tb_ysyx_040750_iter_div;

    localparam int XLEN = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   check_count = 0;
    int   error_count = 0;

    ysyx_040750_iter_div_if #(.XLEN(XLEN)) bus ();

    ysyx_040750_iter_div #(
        .XLEN(XLEN)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        check_count++;
        if (got !== exp) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
        end
    endtask

    // Reference: RISC-V DIV/DIVU/REM/REMU and their W forms, plain arithmetic.
    function automatic void refDivide(input logic [63:0] a, input logic [63:0] b,
                                      input bit sgn, input bit wrd,
                                      output logic [63:0] q, output logic [63:0] r,
                                      output bit special);
        logic [31:0] a32, b32, q32, r32;
        int          sa32, sb32;
        longint      sa64, sb64;
        a32 = a[31:0];
        b32 = b[31:0];
        if (wrd) begin
            special = (b32 == 32'd0) || (sgn && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF);
            if (b32 == 32'd0) begin
                q32 = 32'hFFFF_FFFF;
                r32 = a32;
            end else if (sgn && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
                q32 = a32;
                r32 = 32'd0;
            end else if (sgn) begin
                sa32 = a32;
                sb32 = b32;
                q32  = sa32 / sb32;
                r32  = sa32 % sb32;
            end else begin
                q32 = a32 / b32;
                r32 = a32 % b32;
            end
            q = {{32{q32[31]}}, q32};
            r = {{32{r32[31]}}, r32};
        end else begin
            special = (b == 64'd0) || (sgn && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF);
            if (b == 64'd0) begin
                q = 64'hFFFF_FFFF_FFFF_FFFF;
                r = a;
            end else if (sgn && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) begin
                q = a;
                r = 64'd0;
            end else if (sgn) begin
                sa64 = a;
                sb64 = b;
                q    = sa64 / sb64;
                r    = sa64 % sb64;
            end else begin
                q = a / b;
                r = a % b;
            end
        end
    endfunction

    // Full transaction: accept, scramble inputs, measure latency, hold the
    // result under backpressure for 'hold' cycles, then retire it.
    task automatic applyStimulus(input string tag, input logic [63:0] a, input logic [63:0] b,
                                 input bit sgn, input bit wrd, input int hold);
        logic [63:0] exp_q, exp_r;
        bit          special;
        int          exp_lat;
        int          lat;
        refDivide(a, b, sgn, wrd, exp_q, exp_r, special);
`ifdef YSYX_040750_DIV_FASTPATH_EN
        exp_lat = special ? 1 : (wrd ? 34 : 66);
`else
        exp_lat = wrd ? 34 : 66;
`endif
        checkOutput({tag, ".ready_before"}, 64'(bus.div_ready), 64'd1);
        bus.dividend  = a;
        bus.divisor   = b;
        bus.is_signed = sgn;
        bus.div_word  = wrd;
        bus.div_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.div_valid = 1'b0;
        bus.dividend  = {$urandom, $urandom};
        bus.divisor   = {$urandom, $urandom};
        bus.is_signed = 1'($urandom);
        bus.div_word  = 1'($urandom);
        lat = 1;
        while (!bus.out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput({tag, ".latency"}, 64'(lat), 64'(exp_lat));
        checkOutput({tag, ".quotient"}, bus.quotient, exp_q);
        checkOutput({tag, ".remainder"}, bus.remainder, exp_r);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            #1;
            checkOutput({tag, ".hold_valid"}, 64'(bus.out_valid), 64'd1);
            checkOutput({tag, ".hold_ready"}, 64'(bus.div_ready), 64'd0);
            checkOutput({tag, ".hold_quotient"}, bus.quotient, exp_q);
            checkOutput({tag, ".hold_remainder"}, bus.remainder, exp_r);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        checkOutput({tag, ".valid_after"}, 64'(bus.out_valid), 64'd0);
        checkOutput({tag, ".ready_after"}, 64'(bus.div_ready), 64'd1);
    endtask

    // Starts a long operation and leaves it running for 'cycles' edges.
    task automatic startLongOp(input int cycles);
        bus.dividend  = {$urandom, $urandom};
        bus.divisor   = {32'd0, $urandom} | 64'd3;
        bus.is_signed = 1'b0;
        bus.div_word  = 1'b0;
        bus.div_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.div_valid = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic watchNoResult(input string tag);
        bit seen;
        seen = 1'b0;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen = 1'b1;
        end
        checkOutput(tag, 64'(seen), 64'd0);
    endtask

    initial begin
        logic [63:0] a, b;
        int          mode;

        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.is_signed = 1'b0;
        bus.div_word  = 1'b0;
        bus.div_valid = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset.div_ready", 64'(bus.div_ready), 64'd1);
        checkOutput("reset.out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("reset.quotient", bus.quotient, 64'd0);
        checkOutput("reset.remainder", bus.remainder, 64'd0);
        rst_n = 1'b1;

        applyStimulus("neg7_div2", 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b0, 0);
        applyStimulus("word_u_big", 64'h0000_0001_8000_0000, 64'd1, 1'b0, 1'b1, 0);
        applyStimulus("div_zero", 64'd42, 64'd0, 1'b1, 1'b0, 0);
        applyStimulus("signed_ovf", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 0);
        applyStimulus("word_ovf", 64'h1234_5678_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b1, 0);
        applyStimulus("word_zero_u", 64'hDEAD_BEEF_8765_4321, 64'h0000_ABCD_0000_0000, 1'b0, 1'b1, 0);
        applyStimulus("u64_max", 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 1'b0, 1'b0, 0);
        applyStimulus("backpressure", 64'd100, 64'd7, 1'b0, 1'b0, 10);

        for (int i = 0; i < 40; i++) begin
            mode = $urandom_range(0, 4);
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            case (mode)
                1: begin
                    b = 64'($urandom_range(1, 20));
                    if ($urandom_range(0, 1) == 1) b = -b;
                end
                2: b = ($urandom_range(0, 1) == 1) ? 64'd0 : {$urandom, 32'd0};
                3: begin
                    a = 64'($urandom_range(0, 1000));
                    if ($urandom_range(0, 1) == 1) a = -a;
                end
                4: begin
                    a = {$urandom, 32'h8000_0000};
                    if ($urandom_range(0, 1) == 1) a = 64'h8000_0000_0000_0000;
                    b = 64'hFFFF_FFFF_FFFF_FFFF;
                end
                default: ;
            endcase
            applyStimulus($sformatf("rand%0d", i), a, b, 1'($urandom), 1'($urandom),
                          int'($urandom_range(0, 2)));
        end

        // Flush in the middle of an operation, with a competing request.
        startLongOp(19);
        bus.flush     = 1'b1;
        bus.div_valid = 1'b1;
        bus.dividend  = 64'd55;
        bus.divisor   = 64'd5;
        @(posedge clk);
        #1;
        bus.flush     = 1'b0;
        bus.div_valid = 1'b0;
        checkOutput("flush.div_ready", 64'(bus.div_ready), 64'd1);
        checkOutput("flush.out_valid", 64'(bus.out_valid), 64'd0);
        watchNoResult("flush.no_result");
        applyStimulus("after_flush", 64'd100, 64'd7, 1'b0, 1'b0, 0);

        // Reset in the middle of an operation.
        startLongOp(29);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkOutput("midreset.div_ready", 64'(bus.div_ready), 64'd1);
        checkOutput("midreset.out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("midreset.quotient", bus.quotient, 64'd0);
        checkOutput("midreset.remainder", bus.remainder, 64'd0);
        watchNoResult("midreset.no_result");
        applyStimulus("after_reset", 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 1'b1, 1'b0, 1);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule

// File: doc/ysyx_040750_iter_div.md
YSYX_040750_ITER_DIV -- requirements
Module: ysyx_040750_iter_div

Interface
REQ-001 SHALL have parameter XLEN, default 64: operand/result width; legal values 32 or 64.
REQ-002 SHALL have port clk, input, 1: single clock, all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-004 SHALL have port dividend, input, XLEN: numerator.
REQ-005 SHALL have port divisor, input, XLEN: denominator.
REQ-006 SHALL have port is_signed, input, 1: two's-complement operation when 1.
REQ-007 SHALL have port div_word, input, 1: 32-bit word operation (RV64 DIVW/REMW class); ignored when XLEN==32.
REQ-008 SHALL have ports div_valid (input, 1) and div_ready (output, 1): request handshake.
REQ-009 SHALL have port flush, input, 1: kill any operation in progress.
REQ-010 SHALL have ports out_valid (output, 1) and out_ready (input, 1): result handshake.
REQ-011 SHALL have ports quotient and remainder, outputs, XLEN each: registered results.

Function
REQ-012 SHALL implement states IDLE, CALC, FIX, DONE; div_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-013 SHALL accept a request when div_valid&&div_ready at a rising edge, latching absolute operands, sign flags, div_word; IDLE->CALC.
REQ-014 SHALL perform one restoring radix-2 step per CALC cycle, N steps where N=32 when div_word (or XLEN==32), else XLEN.
REQ-015 SHALL move CALC->FIX after step N, apply sign correction (quotient negative iff operand signs differ, remainder takes dividend sign) in FIX, then FIX->DONE with results registered.
REQ-016 SHALL assert out_valid exactly N+2 cycles after the accepting edge (64-bit: 66; word: 34).
REQ-017 SHALL hold quotient/remainder/out_valid stable in DONE until out_valid&&out_ready, then DONE->IDLE; div_ready rises the cycle after.
REQ-018 SHALL, in word mode, use dividend[31:0]/divisor[31:0] (sign- or zero-extended per is_signed) and sign-extend bit 31 of both 32-bit results to XLEN, for signed and unsigned.
REQ-019 SHALL, for divisor==0, return quotient all-ones (operation width, then extended per REQ-018) and remainder = dividend.
REQ-020 SHALL, for signed overflow (most-negative / -1), return quotient = dividend and remainder = 0.
REQ-021 SHALL give flush priority over all other events: next state IDLE, out_valid low, result discarded; a div_valid in the same cycle as flush is not accepted.
REQ-022 SHALL ignore operand/control inputs outside the accepting edge; changes mid-operation have no effect.

Reset
REQ-023 SHALL, when rst_n==0 at a rising edge, enter IDLE and clear quotient, remainder, iteration counter, and all datapath registers to 0; div_ready=1, out_valid=0 from the first cycle after reset.
REQ-024 SHALL abort any in-flight operation on reset with no result emitted; reset overrides flush.

Configuration
REQ-025 SHALL honour macro YSYX_040750_DIV_FASTPATH_EN: when defined, divide-by-zero and signed-overflow requests go IDLE->DONE directly, out_valid one cycle after accept.
REQ-026 SHALL, without YSYX_040750_DIV_FASTPATH_EN, process those cases through full CALC/FIX with the same latency as REQ-016 and identical result values.

Structure
REQ-027 SHALL take the state enum, XLEN default, and word-width constant (32) from shared package ysyx_040750_div_pkg.
REQ-028 SHALL place the single restoring step (shifted partial remainder minus divisor, quotient bit, next remainder) in combinational sub-module ysyx_040750_div_step, instantiated once.

Verification
REQ-029 SHALL cover signed 64-bit: dividend=-7, divisor=2 -> quotient=-3, remainder=-1, out_valid 66 cycles after accept.
REQ-030 SHALL cover unsigned word mode: dividend=0x0000_0001_8000_0000, divisor=1 -> quotient=remainder-free 0xFFFF_FFFF_8000_0000, remainder=0, latency 34.
REQ-031 SHALL cover divide-by-zero: dividend=42, divisor=0, signed -> quotient=0xFFFF_FFFF_FFFF_FFFF, remainder=42; latency 1 with FASTPATH_EN, 66 without.
REQ-032 SHALL cover signed overflow: dividend=0x8000_0000_0000_0000, divisor=-1 -> quotient=0x8000_0000_0000_0000, remainder=0.
REQ-033 SHALL cover backpressure and flush: out_ready low 10 cycles -> results stable, div_ready low; flush at CALC cycle 20 -> IDLE next cycle, no out_valid, following 100/7 request -> 14, 2.
REQ-034 SHALL cover reset mid-CALC: rst_n low for one edge at CALC cycle 30 -> div_ready=1, out_valid=0, outputs 0 next cycle.
